fetch_decode_queue: RTL

- Instruction queue between the fetch stage and the decode stage of the RV64I core.
- Captures {pc, instr} pairs from fetch under a valid/ready handshake and holds up to DEPTH of them in order.
- Presents the oldest entry to decode with pre-extracted register/opcode fields and fault flags.
- Absorbs decode stalls and discards in-flight instructions on a redirect (flush).

---
 rtl/fetch_decode_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// FetchDecodeQueue (module fetch_decode_queue)
//
// Purpose:
//   In-order instruction queue between the fetch and decode stages of the
//   RV64I core. Fetch pushes {pc, instr} pairs under a valid/ready handshake.
//   Decode sees the oldest entry together with pre-extracted register and
//   opcode fields and two fault flags. A flush discards every queued entry.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   flush          synchronous discard of all entries (redirect)
//   in_valid       fetch presents a pc/instr pair
//   in_ready       queue can accept a push this cycle (registered state only)
//   in_pc          pc of the incoming instruction
//   in_instr       incoming instruction
//   out_valid      head entry valid
//   out_ready      decode consumes the head this cycle
//   out_pc         pc of the head entry
//   out_pc_plus4   out_pc + 4, wrapping at 64 bits
//   out_instr      head instruction
//   out_opcode     out_instr[6:0]
//   out_rd         out_instr[11:7]
//   out_funct3     out_instr[14:12]
//   out_rs1        out_instr[19:15]
//   out_rs2        out_instr[24:20]
//   out_illegal    head valid and not a 32-bit encoding (no compressed ISA)
//   out_misaligned head valid and pc not word aligned
//   count          current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [63:0]      out_pc_plus4,
  output logic [31:0]      out_instr,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [63:0]    r_memPc    [DEPTH];
  logic [31:0]    r_memInstr [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0] r_count;

  logic        w_push;
  logic        w_pop;
  logic [63:0] w_headPc;
  logic [31:0] w_headInstr;

  // Handshake qualifiers. Both depend only on registered occupancy, so
  // in_ready never combinationally follows out_ready; a full queue refuses a
  // push even when decode pops in the same cycle.
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Pointer, occupancy and storage update. Flush wins over push/pop and only
  // rewinds the bookkeeping; stale storage is harmless because out_valid
  // drops with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_memPc[i]    <= '0;
        r_memInstr[i] <= '0;
      end
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_memPc[r_wrPtr]    <= in_pc;
        r_memInstr[r_wrPtr] <= in_instr;
        r_wrPtr             <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head decode: everything decode needs is sliced straight out of the
  // oldest entry. When empty these show the stale head; decode must qualify
  // on out_valid, and the fault flags are gated here for that reason.
  assign w_headPc    = r_memPc[r_rdPtr];
  assign w_headInstr = r_memInstr[r_rdPtr];

  assign out_pc         = w_headPc;
  assign out_pc_plus4   = w_headPc + 64'd4;
  assign out_instr      = w_headInstr;
  assign out_opcode     = w_headInstr[6:0];
  assign out_rd         = w_headInstr[11:7];
  assign out_funct3     = w_headInstr[14:12];
  assign out_rs1        = w_headInstr[19:15];
  assign out_rs2        = w_headInstr[24:20];
  assign out_illegal    = out_valid & (w_headInstr[1:0] != 2'b11);
  assign out_misaligned = out_valid & (w_headPc[1:0] != 2'b00);
  assign count          = r_count;

endmodule
